// File: rtl/maxnet_pkg.sv
// Shared Maxnet parameters and the loader state encoding.
package maxnet_pkg;

    localparam int WIDTH = 4;
    localparam int DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/data_memory_loader.sv
// Sequentially loads DEPTH values from a valid/ready stream, then exposes
// them in parallel and accepts random-access write-back from the datapath.
module data_memory_loader
    import maxnet_pkg::*;
#(
    parameter int WIDTH  = maxnet_pkg::WIDTH,
    parameter int DEPTH  = maxnet_pkg::DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         in_valid,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         in_ready,
    input  logic                         wr_en,
    input  logic [ADDR_W-1:0]            wr_addr,
    input  logic [WIDTH-1:0]             wr_data,
    output logic [DEPTH-1:0][WIDTH-1:0]  entries,
    output logic                         load_done,
    output logic                         busy
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    state_t                       state;
    logic [ADDR_W-1:0]            idx;
    logic [DEPTH-1:0][WIDTH-1:0]  mem;

    assign entries = mem;

    // Status outputs are registered alongside the state so they always agree with it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            idx       <= '0;
            mem       <= '0;
            in_ready  <= 1'b0;
            busy      <= 1'b0;
            load_done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= LOAD;
                        idx      <= '0;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                LOAD: begin
                    if (in_valid && in_ready) begin
                        mem[idx] <= in_data;
                        if (idx == LAST) begin
                            state     <= DONE;
                            idx       <= '0;
                            in_ready  <= 1'b0;
                            busy      <= 1'b0;
                            load_done <= 1'b1;
                        end else begin
                            idx <= idx + ADDR_W'(1);
                        end
                    end
                end
                DONE: begin
                    // A restart wins over a same-cycle write-back.
                    if (start) begin
                        state     <= LOAD;
                        idx       <= '0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b1;
                        load_done <= 1'b0;
                    end else if (wr_en) begin
                        mem[wr_addr] <= wr_data;
                    end
                end
                default: begin
                    state     <= IDLE;
                    idx       <= '0;
                    in_ready  <= 1'b0;
                    busy      <= 1'b0;
                    load_done <= 1'b0;
                end
            endcase
        end
    end

endmodule
